serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl_if.sv | 25 ++
 rtl/serial_sub_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// The requester drives the master side; the subtractor is the slave.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared Full_sub cell, LSB first, one bit per clock.
// Results (diff/bout/ovf) update only on the RUN->DONE edge and hold until the next one.
module Full_sub (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sub,
    output logic bo
);
    assign sub = a ^ b ^ c;
    assign bo  = (~a & (b | c)) | (b & c);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             amsb_q;
    logic             bmsb_q;
    logic             bout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             sub_w;
    logic             bo_w;

    Full_sub u_cell (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .c   (borrow_q),
        .sub (sub_w),
        .bo  (bo_w)
    );

    // Result register with this cycle's difference bit shifted into the MSB.
    always_comb begin
        r_d = {sub_w, r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        amsb_q   <= bus.a[WIDTH-1];
                        bmsb_q   <= bus.b[WIDTH-1];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    r_q      <= r_d;
                    borrow_q <= bo_w;
                    if (cnt_q == LAST) begin
                        // Counter is left at WIDTH-1 rather than wrapping.
                        diff_q  <= r_d;
                        bout_q  <= bo_w;
                        ovf_q   <= (amsb_q ^ bmsb_q) & (r_d[WIDTH-1] ^ amsb_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=3 against an arithmetic
// timeline model: result = a - b - bin, busy for WIDTH cycles, then a one-cycle done.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(3)) if3 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_sub_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    int checks = 0;
    int errors = 0;

    int wid[2] = '{8, 3};
    // ph: 0 idle, 1..W busy cycle number, W+1 done cycle
    int ph[2]  = '{0, 0};
    int md[2]  = '{0, 0};
    int mb[2]  = '{0, 0};
    int mo[2]  = '{0, 0};
    int pd[2]  = '{0, 0};
    int pb[2]  = '{0, 0};
    int po[2]  = '{0, 0};
    bit model_live = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic calc(int w, int a, int b, int bi, output int d, output int bo, output int ov);
        int m, sa, sb, r;
        m  = 1 << w;
        d  = (a - b - bi) & (m - 1);
        bo = (a < b + bi) ? 1 : 0;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        r  = sa - sb - bi;
        ov = (r < -(m / 2) || r > m / 2 - 1) ? 1 : 0;
    endtask

    task automatic model_step(int s, bit st, int a, int b, bit bi);
        if (rst) begin
            ph[s] = 0; md[s] = 0; mb[s] = 0; mo[s] = 0;
        end else if (ph[s] == 0) begin
            if (st) begin
                calc(wid[s], a, b, int'(bi), pd[s], pb[s], po[s]);
                ph[s] = 1;
            end
        end else if (ph[s] < wid[s]) begin
            ph[s]++;
        end else if (ph[s] == wid[s]) begin
            ph[s] = wid[s] + 1;
            md[s] = pd[s]; mb[s] = pb[s]; mo[s] = po[s];
        end else begin
            ph[s] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, if8.start, int'(if8.a), int'(if8.b), if8.bin);
        model_step(1, if3.start, int'(if3.a), int'(if3.b), if3.bin);
        model_live = 1'b1;
    end

    // Every cycle, both instances against the model, sampled after the edge settles.
    always @(posedge clk) begin
        #1;
        if (model_live) begin
            chk("w8_busy", int'(if8.busy), (ph[0] >= 1 && ph[0] <= 8) ? 1 : 0);
            chk("w8_done", int'(if8.done), (ph[0] == 9) ? 1 : 0);
            chk("w8_diff", int'(if8.diff), md[0]);
            chk("w8_bout", int'(if8.bout), mb[0]);
            chk("w8_ovf",  int'(if8.ovf),  mo[0]);
            chk("w3_busy", int'(if3.busy), (ph[1] >= 1 && ph[1] <= 3) ? 1 : 0);
            chk("w3_done", int'(if3.done), (ph[1] == 4) ? 1 : 0);
            chk("w3_diff", int'(if3.diff), md[1]);
            chk("w3_bout", int'(if3.bout), mb[1]);
            chk("w3_ovf",  int'(if3.ovf),  mo[1]);
        end
    end

    task automatic drive(int s, bit st, int a, int b, bit bi);
        if (s == 0) begin
            if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bi;
        end else begin
            if3.start = st; if3.a = a[2:0]; if3.b = b[2:0]; if3.bin = bi;
        end
    endtask

    function automatic bit get_busy(int s);
        return (s == 0) ? if8.busy : if3.busy;
    endfunction

    function automatic bit get_done(int s);
        return (s == 0) ? if8.done : if3.done;
    endfunction

    // Returns at the negedge inside the done cycle, results valid.
    task automatic run_op(int s, int a, int b, bit bi, output int nbusy);
        bit got;
        got   = 1'b0;
        nbusy = 0;
        @(negedge clk);
        drive(s, 1'b1, a, b, bi);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(s, 1'b0, a, b, bi);
            if (get_done(s)) begin
                got = 1'b1;
                break;
            end
            if (get_busy(s)) nbusy++;
        end
        chk("done_seen", int'(got), 1);
    endtask

    initial begin
        int nb, ed, eb, eo, dones;
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(if8.busy), 0);
        chk("rst_diff", int'(if8.diff), 0);

        run_op(0, 'h5A, 'h3C, 1'b0, nb);
        chk("t1_busy_cycles", nb, 8);
        chk("t1_diff", int'(if8.diff), 'h1E);
        chk("t1_bout", int'(if8.bout), 0);
        chk("t1_ovf", int'(if8.ovf), 0);
        chk("t1_model_pin", md[0], 'h1E);

        run_op(0, 'h00, 'h01, 1'b0, nb);
        chk("t2_diff", int'(if8.diff), 'hFF);
        chk("t2_bout", int'(if8.bout), 1);
        chk("t2_ovf", int'(if8.ovf), 0);
        run_op(0, 'h00, 'h00, 1'b1, nb);
        chk("t3_diff", int'(if8.diff), 'hFF);
        chk("t3_bout", int'(if8.bout), 1);
        run_op(0, 'h80, 'h01, 1'b0, nb);
        chk("t4_diff", int'(if8.diff), 'h7F);
        chk("t4_bout", int'(if8.bout), 0);
        chk("t4_ovf", int'(if8.ovf), 1);
        chk("t4_model_pin", mo[0], 1);

        // start pulses during RUN and DONE must be ignored
        @(negedge clk); drive(0, 1'b1, 'h10, 'h01, 1'b0);
        @(negedge clk); drive(0, 1'b0, 'h10, 'h01, 1'b0);
        @(negedge clk);
        @(negedge clk); drive(0, 1'b1, 'hFF, 'hFF, 1'b0);
        @(negedge clk); drive(0, 1'b0, 'hFF, 'hFF, 1'b0);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (if8.done) begin got = 1'b1; break; end
                @(negedge clk);
            end
            chk("ign_done_seen", int'(got), 1);
        end
        chk("ign_diff", int'(if8.diff), 'h0F);
        drive(0, 1'b1, 'hFF, 'hFF, 1'b0);
        @(negedge clk); drive(0, 1'b0, 'hFF, 'hFF, 1'b0);
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.busy) nb++;
        end
        chk("ign_no_second_busy", nb, 0);
        chk("ign_diff_held", int'(if8.diff), 'h0F);

        // reset at the 4th RUN cycle aborts with no done
        run_op(0, 'h5A, 'h3C, 1'b0, nb);
        chk("rr_prev_diff", int'(if8.diff), 'h1E);
        @(negedge clk); drive(0, 1'b1, 'h33, 'h11, 1'b0);
        @(negedge clk); drive(0, 1'b0, 'h33, 'h11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rr_busy", int'(if8.busy), 0);
        chk("rr_diff", int'(if8.diff), 0);
        chk("rr_bout", int'(if8.bout), 0);
        chk("rr_ovf", int'(if8.ovf), 0);
        dones = 0;
        repeat (14) begin
            @(negedge clk);
            if (if8.done) dones++;
        end
        chk("rr_no_done", dones, 0);

        // exhaustive WIDTH=3
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    run_op(1, a, b, bi[0], nb);
                    chk("w3_busy_cycles", nb, 3);
                    calc(3, a, b, bi, ed, eb, eo);
                    chk("w3_ex_diff", int'(if3.diff), ed);
                    chk("w3_ex_bout", int'(if3.bout), eb);
                    chk("w3_ex_ovf", int'(if3.ovf), eo);
                end

        // random starts, operands and occasional resets on WIDTH=8
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            drive(0, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk); rst = 1'b0;

        // start held high: back-to-back operations every WIDTH+2 cycles
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            drive(0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk); drive(0, 1'b0, 0, 0, 1'b0);
        repeat (14) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
